// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: packs a byte stream (MSB first) into 32-bit words,
// writes them to word addresses 0..len-1 and holds the CPU for the whole load.
module instr_mem_loader #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_len,
   input  logic              i_byte_valid,
   input  logic [7:0]        i_byte,
   output logic              o_byte_ready,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [31:0]       o_wr_data,
   output logic              o_cpu_hold,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned BCNT_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
   logic [ADDR_W-1:0]   len_q, len_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic                err_q, err_d;

   logic                ready_q, ready_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [WORD_W-1:0]   wr_data_q, wr_data_d;
   logic                hold_q, hold_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                len_ok_c;
   logic                accept_c;
   logic [ADDR_W-1:0]   word_cnt_inc_c;

   assign len_ok_c       = (i_len != '0) && (i_len <= ADDR_W'(DEPTH));
   assign accept_c       = (state_q == RECV) && i_byte_valid;
   assign word_cnt_inc_c = word_cnt_q + ADDR_W'(1);

   // State and datapath registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         byte_cnt_q <= '0;
         word_cnt_q <= '0;
         len_q      <= '0;
         word_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         word_cnt_q <= word_cnt_d;
         len_q      <= len_d;
         word_q     <= word_d;
         err_q      <= err_d;
      end
   end

   // Next-state, counter and packing logic
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      word_cnt_d = word_cnt_q;
      len_d      = len_q;
      word_d     = word_q;
      err_d      = err_q;

      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               if (len_ok_c) begin
                  len_d      = i_len;
                  byte_cnt_d = '0;
                  word_cnt_d = '0;
                  word_d     = '0;
                  err_d      = 1'b0;
                  state_d    = RECV;
               end else begin
                  err_d      = 1'b1;
               end
            end
         end
         RECV: begin
            if (accept_c) begin
               word_d = {word_q[WORD_W-BYTE_W-1:0], i_byte};
               if (byte_cnt_q == BCNT_W'(3)) begin
                  byte_cnt_d = '0;
                  state_d    = WRITE;
               end else begin
                  byte_cnt_d = byte_cnt_q + BCNT_W'(1);
               end
            end
         end
         WRITE: begin
            word_cnt_d = word_cnt_inc_c;
            state_d    = (word_cnt_inc_c == len_q) ? DONE : RECV;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are registered copies of what the next state decodes to,
   // so each appears in the same cycle the state itself is entered.
   always_comb begin
      ready_d   = (state_d == RECV);
      wr_en_d   = (state_d == WRITE);
      wr_addr_d = (state_d == WRITE) ? word_cnt_q : '0;
      wr_data_d = (state_d == WRITE) ? word_d : '0;
      hold_d    = (state_d != IDLE);
      busy_d    = (state_d != IDLE);
      done_d    = (state_d == DONE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ready_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         hold_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         ready_q   <= ready_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         hold_q    <= hold_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign o_byte_ready = ready_q;
   assign o_wr_en      = wr_en_q;
   assign o_wr_addr    = wr_addr_q;
   assign o_wr_data    = wr_data_q;
   assign o_cpu_hold   = hold_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_err        = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed and randomized program images checked
// against a byte-queue model of the expected word writes.
module tb_instr_mem_loader;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DEPTH  = 32;

   logic              clk;
   logic              rst_n;
   logic              i_start;
   logic [ADDR_W-1:0] i_len;
   logic              i_byte_valid;
   logic [7:0]        i_byte;
   logic              o_byte_ready;
   logic              o_wr_en;
   logic [ADDR_W-1:0] o_wr_addr;
   logic [31:0]       o_wr_data;
   logic              o_cpu_hold;
   logic              o_busy;
   logic              o_done;
   logic              o_err;

   int unsigned n_checks;
   int unsigned n_pass;
   logic [7:0]  img[$];

   instr_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (i_start),
      .i_len        (i_len),
      .i_byte_valid (i_byte_valid),
      .i_byte       (i_byte),
      .o_byte_ready (o_byte_ready),
      .o_wr_en      (o_wr_en),
      .o_wr_addr    (o_wr_addr),
      .o_wr_data    (o_wr_data),
      .o_cpu_hold   (o_cpu_hold),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_err        (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Word k of the image, first byte in bits [31:24]
   function automatic logic [31:0] exp_word(input int unsigned k);
      logic [31:0] w;
      w = 32'(img[4*k]) * 32'h0100_0000 + 32'(img[4*k+1]) * 32'h0001_0000
        + 32'(img[4*k+2]) * 32'h0000_0100 + 32'(img[4*k+3]);
      return w;
   endfunction

   task automatic check_all_low(input string tag);
      check({tag, "_ready"}, 32'(o_byte_ready), 32'd0);
      check({tag, "_wr"},    32'(o_wr_en) | o_wr_addr | o_wr_data, 32'd0);
      check({tag, "_hold"},  32'(o_cpu_hold), 32'd0);
      check({tag, "_busy"},  32'(o_busy), 32'd0);
      check({tag, "_done"},  32'(o_done), 32'd0);
   endtask

   // Drives one load of img; valid_pct<0 toggles valid every other cycle.
   task automatic run_load(input int unsigned len, input int valid_pct, input bit late_start);
      int unsigned idx;
      int unsigned wr_idx;
      int unsigned cyc;
      bit done_seen;
      bit late_done;
      bit prev_wr;
      idx = 0; wr_idx = 0; cyc = 0; done_seen = 0; late_done = 0; prev_wr = 0;
      @(negedge clk);
      i_start = 1'b1;
      i_len   = ADDR_W'(len);
      @(negedge clk);
      i_start = 1'b0;
      i_len   = ADDR_W'($urandom);
      check("err_clear", 32'(o_err), 32'd0);
      check("hold_rise", 32'(o_cpu_hold), 32'd1);
      while (!done_seen && cyc < 4000) begin
         if (o_wr_en) begin
            check("wr_addr", o_wr_addr, 32'(wr_idx));
            check("wr_data", o_wr_data, exp_word(wr_idx));
            wr_idx++;
         end else begin
            check("wr_bus_idle", o_wr_addr | o_wr_data, 32'd0);
         end
         if (o_done) begin
            check("done_count", 32'(wr_idx), 32'(len));
            check("done_after_wr", 32'(prev_wr), 32'd1);
            done_seen = 1'b1;
         end
         check("hold_busy", {30'd0, o_cpu_hold, o_busy}, 32'd3);
         prev_wr = o_wr_en;
         if (late_start && !late_done && o_byte_ready && idx >= 2) begin
            i_start   = 1'b1;
            i_len     = ADDR_W'(5);
            late_done = 1'b1;
         end else begin
            i_start = 1'b0;
         end
         if (valid_pct < 0) i_byte_valid = (idx < img.size()) && cyc[0];
         else i_byte_valid = (idx < img.size()) && (int'($urandom_range(99)) < valid_pct);
         i_byte = i_byte_valid ? img[idx] : 8'($urandom);
         if (o_byte_ready && i_byte_valid) idx++;
         @(negedge clk);
         cyc++;
      end
      i_byte_valid = 1'b0;
      i_start      = 1'b0;
      check("done_seen", 32'(done_seen), 32'd1);
      check("bytes_used", 32'(idx), 32'(len * 4));
      check_all_low("after_done");
   endtask

   task automatic illegal_start(input logic [ADDR_W-1:0] len);
      @(negedge clk);
      i_start = 1'b1;
      i_len   = len;
      i_byte_valid = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("illegal_err", 32'(o_err), 32'd1);
         check_all_low("illegal");
         @(negedge clk);
      end
      i_byte_valid = 1'b0;
   endtask

   task automatic set_img(input int unsigned nwords);
      img.delete();
      for (int i = 0; i < int'(nwords) * 4; i++) img.push_back(8'($urandom));
   endtask

   initial begin
      int unsigned acc;
      n_checks = 0; n_pass = 0;
      rst_n = 1'b0; i_start = 1'b0; i_len = '0; i_byte_valid = 1'b0; i_byte = '0;
      repeat (3) @(negedge clk);
      check_all_low("reset");
      check("reset_err", 32'(o_err), 32'd0);
      rst_n = 1'b1;

      // Basic load, then same image with stalls
      img = '{8'h00, 8'h22, 8'h60, 8'h20, 8'h00, 8'hA3, 8'h58, 8'h25};
      check("img_w0", exp_word(0), 32'h0022_6020);
      check("img_w1", exp_word(1), 32'h00A3_5825);
      run_load(2, 100, 1'b0);
      run_load(2, -1, 1'b0);

      // Illegal lengths, then a legal start clears the error
      illegal_start(ADDR_W'(0));
      illegal_start(ADDR_W'(DEPTH + 1));
      img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_load(1, 70, 1'b0);

      // Asynchronous reset mid-load, then a clean single-word load
      @(negedge clk);
      i_start = 1'b1; i_len = ADDR_W'(1);
      @(negedge clk);
      i_start = 1'b0;
      acc = 0;
      for (int c = 0; c < 20 && acc < 2; c++) begin
         i_byte_valid = 1'b1;
         i_byte = (acc == 0) ? 8'hAA : 8'hBB;
         if (o_byte_ready) acc++;
         @(negedge clk);
      end
      i_byte_valid = 1'b0;
      check("abort_hold_pre", 32'(o_cpu_hold), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_all_low("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_all_low("post_reset");
      img = '{8'h8C, 8'h02, 8'h00, 8'h02};
      run_load(1, 100, 1'b0);

      // Start pulse while loading is ignored
      img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      run_load(2, 80, 1'b1);

      // Randomized images, including the full-depth boundary
      set_img(DEPTH);
      run_load(DEPTH, 60, 1'b0);
      for (int t = 0; t < 8; t++) begin
         int unsigned n;
         n = $urandom_range(DEPTH, 1);
         set_img(n);
         run_load(n, int'($urandom_range(100, 20)), t[0]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
